// File: rtl/audio_i2s_pkg.sv
// rtl/audio_i2s_pkg.sv - shared constants and types for the I2S receive path
package audio_i2s_pkg;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  localparam int I2S_WIDTH_DEFAULT  = 24;
  localparam int I2S_WIDTH_ALT      = 16;
  localparam int I2S_MIN_OVERSAMPLE = 4;
  localparam int I2S_MIN_SYNC       = 2;

  typedef enum logic [1:0] {
    ST_UNARMED   = 2'd0,
    ST_NO_LEFT   = 2'd1,
    ST_HAVE_LEFT = 2'd2
  } arm_state_t;

endpackage

// File: rtl/audio_i2s_receiver_if.sv
// rtl/audio_i2s_receiver_if.sv - codec serial lines and parallel sample outputs
interface audio_i2s_receiver_if #(
  parameter int WIDTH = 24
);
  logic             iAUD_BCK;
  logic             iAUD_LRCK;
  logic             iAUD_ADCDAT;
  logic [WIDTH-1:0] oL_SAMPLE;
  logic [WIDTH-1:0] oR_SAMPLE;
  logic             oVALID;
  logic             oSHORT_ERR;

  modport master (
    output iAUD_BCK, iAUD_LRCK, iAUD_ADCDAT,
    input  oL_SAMPLE, oR_SAMPLE, oVALID, oSHORT_ERR
  );

  modport slave (
    input  iAUD_BCK, iAUD_LRCK, iAUD_ADCDAT,
    output oL_SAMPLE, oR_SAMPLE, oVALID, oSHORT_ERR
  );
endinterface

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - multi-flop synchroniser with registered rise detect
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sync_q;
  logic              last_q;
  logic              rise_q;

  // level is delayed once more so it lines up with the registered rise pulse
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~last_q;
    end
  end

  assign level = last_q;
  assign rise  = rise_q;
endmodule

// File: rtl/audio_i2s_receiver.sv
// rtl/audio_i2s_receiver.sv - oversampled I2S ADC deserialiser, one strobe per L/R pair
module audio_i2s_receiver
  import audio_i2s_pkg::*;
#(
  parameter int WIDTH       = I2S_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input logic iCLK,
  input logic iRST,
  audio_i2s_receiver_if.slave aud
);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  logic bck_rise, lrck_s, dat_s;
  logic bck_level_unused, lrck_rise_unused, dat_rise_unused;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_bck (
    .iCLK(iCLK), .iRST(iRST), .async_in(aud.iAUD_BCK),
    .level(bck_level_unused), .rise(bck_rise)
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_lrck (
    .iCLK(iCLK), .iRST(iRST), .async_in(aud.iAUD_LRCK),
    .level(lrck_s), .rise(lrck_rise_unused)
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_dat (
    .iCLK(iCLK), .iRST(iRST), .async_in(aud.iAUD_ADCDAT),
    .level(dat_s), .rise(dat_rise_unused)
  );

  logic [WIDTH-1:0] sr, word;
  logic [IW-1:0]    idx;
  logic             lrck_prev, boundary, in_range, short_slot;

  always_comb begin
    boundary   = (lrck_s != lrck_prev);
    in_range   = (idx < IW'(WIDTH));
    short_slot = (idx < IW'(WIDTH - 1));
    word       = sr | ({WIDTH{dat_s}} & (TOP_BIT >> idx));
  end

  // Capture stage: every boundary emits a one-cycle slot event to the arming FSM
  logic             ev_q, ev_right_q, ev_short_q;
  logic [WIDTH-1:0] ev_word_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sr         <= '0;
      idx        <= '0;
      lrck_prev  <= 1'b0;
      ev_q       <= 1'b0;
      ev_right_q <= 1'b0;
      ev_short_q <= 1'b0;
      ev_word_q  <= '0;
    end else begin
      ev_q <= 1'b0;
      if (bck_rise) begin
        lrck_prev <= lrck_s;
        if (boundary) begin
          ev_q       <= 1'b1;
          ev_right_q <= (lrck_prev == I2S_RIGHT);
          ev_short_q <= short_slot;
          ev_word_q  <= word;
          sr         <= '0;
          idx        <= '0;
        end else if (in_range) begin
          sr  <= word;
          idx <= idx + IW'(1);
        end
      end
    end
  end

  arm_state_t state, state_nx;
  logic       take_left, emit, flag_short;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ST_UNARMED;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    take_left  = 1'b0;
    emit       = 1'b0;
    flag_short = 1'b0;
    if (ev_q) begin
      case (state)
        ST_UNARMED: state_nx = ST_NO_LEFT;
        ST_NO_LEFT: begin
          flag_short = ev_short_q;
          if (!ev_right_q) begin
            take_left = 1'b1;
            state_nx  = ST_HAVE_LEFT;
          end
        end
        ST_HAVE_LEFT: begin
          flag_short = ev_short_q;
          if (!ev_right_q) begin
            take_left = 1'b1;
          end else begin
            emit     = 1'b1;
            state_nx = ST_NO_LEFT;
          end
        end
        default: state_nx = ST_UNARMED;
      endcase
    end
  end

  logic [WIDTH-1:0] left_hold, l_q, r_q;
  logic             valid_q, short_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      left_hold <= '0;
      l_q       <= '0;
      r_q       <= '0;
      valid_q   <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      valid_q <= emit;
      short_q <= flag_short;
      if (take_left) left_hold <= ev_word_q;
      if (emit) begin
        l_q <= left_hold;
        r_q <= ev_word_q;
      end
    end
  end

  assign aud.oL_SAMPLE  = l_q;
  assign aud.oR_SAMPLE  = r_q;
  assign aud.oVALID     = valid_q;
  assign aud.oSHORT_ERR = short_q;
endmodule

// File: tb/tb_audio_i2s_receiver.sv
// tb/tb_audio_i2s_receiver.sv - directed and scoreboarded bench for audio_i2s_receiver
module tb_audio_i2s_receiver;
  import audio_i2s_pkg::*;

  localparam int WIDTH = 24;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_i2s_receiver_if #(.WIDTH(WIDTH)) aud ();

  audio_i2s_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .iCLK(clk),
    .iRST(rst),
    .aud (aud)
  );

  typedef struct {
    logic [23:0] lw;
    logic [23:0] rw;
    int          slot;
    int          wb;
    int          frames;
    int          lo;
    int          hi;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    int          exp_short;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [23:0] obs_l[$];
  logic [23:0] obs_r[$];
  logic [23:0] exp_lq[$];
  logic [23:0] exp_rq[$];
  int valid_cnt, short_cnt, last_valid_cyc, last_b_e0;
  logic prev_last;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (aud.oVALID) begin
        obs_l.push_back(aud.oL_SAMPLE);
        obs_r.push_back(aud.oR_SAMPLE);
        valid_cnt++;
        last_valid_cyc = cyc;
      end
      if (aud.oSHORT_ERR) short_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic slot_bit(input logic [23:0] w, input int j, input int wb);
    if (j < wb) return w[5'(wb - 1 - j)];
    return 1'b0;
  endfunction

  task automatic clear_obs();
    obs_l.delete();
    obs_r.delete();
    valid_cnt = 0;
    short_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {aud.oL_SAMPLE, aud.oR_SAMPLE, aud.oVALID, aud.oSHORT_ERR}, 64'h0);
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic drive_slot(input logic ch, input logic [23:0] w, input int s, input int wb,
                            input int first, input int last, input int lo, input int hi, input bit jit);
    int jl, jh;
    for (int i = first; i < last; i++) begin
      jl = lo + (jit ? int'($urandom_range(2)) - 1 : 0);
      jh = hi + (jit ? int'($urandom_range(2)) - 1 : 0);
      aud.iAUD_BCK    = 1'b0;
      aud.iAUD_LRCK   = ch;
      aud.iAUD_ADCDAT = (i == 0) ? prev_last : slot_bit(w, i - 1, wb);
      repeat (jl) @(negedge clk);
      aud.iAUD_BCK = 1'b1;
      if (i == 0 && ch == I2S_LEFT) last_b_e0 = cyc + 1;
      repeat (jh) @(negedge clk);
    end
    if (last == s) prev_last = slot_bit(w, s - 1, wb);
  endtask

  task automatic drive_frame(input logic [23:0] l, input logic [23:0] r, input int s, input int wb,
                             input int lo, input int hi, input bit jit);
    drive_slot(I2S_LEFT, l, s, wb, 0, s, lo, hi, jit);
    drive_slot(I2S_RIGHT, r, s, wb, 0, s, lo, hi, jit);
  endtask

  // Opens one more left slot so the last right slot closes, then drains the pipeline
  task automatic tail(input int s, input int wb, input int lo, input int hi);
    drive_slot(I2S_LEFT, 24'h0, s, wb, 0, 2, lo, hi, 1'b0);
    aud.iAUD_BCK = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  vec_t vecs[5];

  initial begin
    logic [23:0] l, r;
    int n;

    vecs[0] = '{24'h800001, 24'h7FFFFE, 32, 24, 4, 4, 4, 24'h800001, 24'h7FFFFE, 0};
    vecs[1] = '{24'hABCDEF, 24'h123456, 24, 24, 4, 2, 2, 24'hABCDEF, 24'h123456, 0};
    vecs[2] = '{24'h00A5A5, 24'h005A5A, 16, 16, 3, 3, 3, 24'hA5A500, 24'h5A5A00, 5};
    vecs[3] = '{24'h000000, 24'hFFFFFF, 24, 24, 3, 1, 3, 24'h000000, 24'hFFFFFF, 0};
    vecs[4] = '{24'hFFFFFF, 24'h000001, 32, 24, 3, 4, 4, 24'hFFFFFF, 24'h000001, 0};

    aud.iAUD_BCK    = 1'b0;
    aud.iAUD_LRCK   = 1'b0;
    aud.iAUD_ADCDAT = 1'b0;
    prev_last       = 1'b0;
    last_b_e0       = 0;
    last_valid_cyc  = 0;
    clear_obs();

    for (int v = 0; v < 5; v++) begin
      prev_last = 1'b0;
      do_reset();
      for (int f = 0; f < vecs[v].frames; f++)
        drive_frame(vecs[v].lw, vecs[v].rw, vecs[v].slot, vecs[v].wb, vecs[v].lo, vecs[v].hi, 1'b0);
      tail(vecs[v].slot, vecs[v].wb, vecs[v].lo, vecs[v].hi);
      check($sformatf("v%0d_valid_count", v), 64'(valid_cnt), 64'(vecs[v].frames - 1));
      for (int k = 0; k < obs_l.size(); k++)
        check($sformatf("v%0d_pair%0d", v, k), {obs_l[k], obs_r[k]}, {vecs[v].exp_l, vecs[v].exp_r});
      check($sformatf("v%0d_short_count", v), 64'(short_cnt), 64'(vecs[v].exp_short));
      check($sformatf("v%0d_latency", v), 64'(last_valid_cyc - last_b_e0), 64'(SYNC + 2));
      check($sformatf("v%0d_hold", v), {aud.oL_SAMPLE, aud.oR_SAMPLE}, {vecs[v].exp_l, vecs[v].exp_r});
    end

    // Reset in the middle of a left slot, then a fresh arming sequence
    prev_last = 1'b0;
    do_reset();
    for (int f = 0; f < 3; f++) drive_frame(24'h111111, 24'h222222, 24, 24, 2, 2, 1'b0);
    drive_slot(I2S_LEFT, 24'h333333, 24, 24, 0, 10, 2, 2, 1'b0);
    repeat (8) @(negedge clk);
    check("mid_pre_valid_count", 64'(valid_cnt), 64'd2);
    check("mid_pre_values", {aud.oL_SAMPLE, aud.oR_SAMPLE}, {24'h111111, 24'h222222});
    do_reset();
    drive_slot(I2S_LEFT, 24'h333333, 24, 24, 10, 24, 2, 2, 1'b0);
    drive_slot(I2S_RIGHT, 24'h444444, 24, 24, 0, 24, 2, 2, 1'b0);
    drive_frame(24'h555555, 24'h666666, 24, 24, 2, 2, 1'b0);
    check("mid_no_early_valid", 64'(valid_cnt), 64'd0);
    tail(24, 24, 2, 2);
    check("mid_post_valid_count", 64'(valid_cnt), 64'd1);
    if (obs_l.size() > 0)
      check("mid_post_pair", {obs_l[0], obs_r[0]}, {24'h555555, 24'h666666});
    check("mid_post_short", 64'(short_cnt), 64'd0);

    // 4x oversample with edge jitter, random words against a scoreboard
    prev_last = 1'b0;
    do_reset();
    exp_lq.delete();
    exp_rq.delete();
    for (int f = 0; f < 300; f++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      drive_frame(l, r, 24, 24, 2, 2, 1'b1);
      if (f > 0) begin
        exp_lq.push_back(l);
        exp_rq.push_back(r);
      end
    end
    tail(24, 24, 2, 2);
    check("jit_valid_count", 64'(obs_l.size()), 64'(exp_lq.size()));
    n = (obs_l.size() < exp_lq.size()) ? obs_l.size() : exp_lq.size();
    for (int k = 0; k < n; k++)
      check($sformatf("jit_pair%0d", k), {obs_l[k], obs_r[k]}, {exp_lq[k], exp_rq[k]});
    check("jit_short", 64'(short_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
